// File: rtl/mem_burst_rd_responder_pkg.sv
// Line geometry and responder FSM encoding, shared with the icache so the
// refill line layout is defined in one place.
package mem_burst_rd_responder_pkg;

    localparam int WORD_W            = 32;
    localparam int REQ_AW            = 32;
    localparam int ICACHE_LINE_WORDS = 8;
    localparam int LAT_W             = 8;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_WAIT = 3'b010;
    localparam logic [2:0] ST_SEND = 3'b100;

    // Byte-address bit where the line index starts.
    function automatic int line_off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/mem_burst_rd_responder_word_array.sv
// Backing store: 2**AW words, one synchronous write port, one asynchronous read port.
module mem_word_array
    import mem_burst_rd_responder_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = WORD_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_burst_rd_responder.sv
// I-cache refill responder: accepts one line read, waits LAT cycles, then
// streams the line as LINE_WORDS beats with a last flag.
module mem_burst_rd_responder
    import mem_burst_rd_responder_pkg::*;
#(
    parameter int MEM_AW     = 12,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int LAT        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              from_cache_rd_req_valid,
    input  logic [REQ_AW-1:0] from_cache_rd_req_addr,
    output logic              to_cache_rd_req_ready,
    output logic              to_cache_rd_rsp_valid,
    output logic [WORD_W-1:0] to_cache_rd_rsp_data,
    output logic              to_cache_rd_rsp_last,
    input  logic              from_cache_rd_rsp_ready,
    input  logic              init_wen,
    input  logic [MEM_AW-1:0] init_addr,
    input  logic [WORD_W-1:0] init_wdata
);

    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = line_off_bits(LINE_WORDS);
    localparam int LW  = MEM_AW - BW;
    localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_CNT   = LAT_W'(LAT);

    logic [2:0]        state_q, state_d;
    logic [LW-1:0]     line_q,  line_d;
    logic [BW-1:0]     beat_q,  beat_d;
    logic [LAT_W-1:0]  lat_q,   lat_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic [WORD_W-1:0] data_q,  data_d;

    logic              load;
    logic [MEM_AW-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [LW-1:0]     req_line;
    logic [REQ_AW-1:0] unused_req_addr;

    // Bits above the backing store alias; bits below the line are ignored.
    assign req_line        = from_cache_rd_req_addr[MEM_AW+1:OFF];
    assign unused_req_addr = from_cache_rd_req_addr;

    mem_word_array #(
        .AW (MEM_AW),
        .DW (WORD_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (init_wen),
        .waddr_i (init_addr),
        .wdata_i (init_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        valid_d = valid_q;
        last_d  = last_q;
        load    = 1'b0;
        rd_addr = {line_q, beat_q};

        case (state_q)
            ST_IDLE: begin
                if (from_cache_rd_req_valid) begin
                    line_d = req_line;
                    beat_d = '0;
                    lat_d  = '0;
                    if (LAT == 0) begin
                        // Zero latency: read straight from the request, line_q not yet valid.
                        load    = 1'b1;
                        rd_addr = {req_line, {BW{1'b0}}};
                        valid_d = 1'b1;
                        last_d  = (LAST_BEAT == '0);
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                lat_d = lat_q + 1'b1;
                if (lat_d == LAT_CNT) begin
                    load    = 1'b1;
                    rd_addr = {line_q, {BW{1'b0}}};
                    valid_d = 1'b1;
                    last_d  = (LAST_BEAT == '0);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (from_cache_rd_rsp_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        load    = 1'b1;
                        rd_addr = {line_q, beat_d};
                        last_d  = (beat_d == LAST_BEAT);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        data_d = load ? rd_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign to_cache_rd_req_ready = (state_q == ST_IDLE) && !rst;
    assign to_cache_rd_rsp_valid = valid_q;
    assign to_cache_rd_rsp_data  = data_q;
    assign to_cache_rd_rsp_last  = last_q;

endmodule

// File: tb/tb_mem_burst_rd_responder.sv
// Scoreboard bench: requests push expected beats, a negedge monitor checks them.
module tb_mem_burst_rd_responder;

    localparam int MEM_AW = 12;
    localparam int DEPTH  = 4096;
    localparam int LAT    = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_ready = 1'b0;
    logic        init_wen = 1'b0;
    logic [11:0] init_addr = '0;
    logic [31:0] init_wdata = '0;

    logic        req_valid0 = 1'b0;
    logic [31:0] req_addr0 = '0;
    logic        req_ready0;
    logic        rsp_valid0;
    logic [31:0] rsp_data0;
    logic        rsp_last0;
    logic        rsp_ready0 = 1'b1;
    logic        init_wen0 = 1'b0;
    logic [11:0] init_addr0 = '0;
    logic [31:0] init_wdata0 = '0;

    mem_burst_rd_responder #(.MEM_AW(MEM_AW), .LINE_WORDS(8), .LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid), .from_cache_rd_req_addr(req_addr),
        .to_cache_rd_req_ready(req_ready), .to_cache_rd_rsp_valid(rsp_valid),
        .to_cache_rd_rsp_data(rsp_data), .to_cache_rd_rsp_last(rsp_last),
        .from_cache_rd_rsp_ready(rsp_ready),
        .init_wen(init_wen), .init_addr(init_addr), .init_wdata(init_wdata)
    );

    mem_burst_rd_responder #(.MEM_AW(MEM_AW), .LINE_WORDS(8), .LAT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .from_cache_rd_req_valid(req_valid0), .from_cache_rd_req_addr(req_addr0),
        .to_cache_rd_req_ready(req_ready0), .to_cache_rd_rsp_valid(rsp_valid0),
        .to_cache_rd_rsp_data(rsp_data0), .to_cache_rd_rsp_last(rsp_last0),
        .from_cache_rd_rsp_ready(rsp_ready0),
        .init_wen(init_wen0), .init_addr(init_addr0), .init_wdata(init_wdata0)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic [31:0] model [DEPTH];
    beat_t       exp_q[$];
    int unsigned first_q[$];

    int unsigned cyc = 0;
    logic        rst_at_edge = 1'b1;
    bit          busy = 1'b0;
    bit          seen_first = 1'b0;
    int unsigned first_cyc = 0;
    int unsigned hs_in_burst = 0;
    int unsigned hs_total = 0;
    int          ready_mode = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion within bound (cycle %0d)", name, cyc);
    endtask

    // Cache-side ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int unsigned i = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = (i % 4 == 0) || (i % 4 == 3);
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            i++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_rsp_last", 32'(rsp_last), 32'd0);
            end else begin
                chk("req_ready", 32'(req_ready), 32'(!busy && !rst));
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got data %h expected no beat (cycle %0d)", rsp_data, cyc);
                    end else begin
                        if (!seen_first) begin
                            if (first_q.size() == 0) fail_now("first_beat_time_missing");
                            else chk("first_beat_cycle", cyc, first_q.pop_front());
                            seen_first = 1'b1;
                            first_cyc  = cyc;
                        end
                        chk("beat_data", rsp_data, exp_q[0].data);
                        chk("beat_last", 32'(rsp_last), 32'(exp_q[0].last));
                        if (rsp_ready) begin
                            hs_in_burst++;
                            hs_total++;
                            if (exp_q[0].last) begin
                                if (ready_mode == 0) chk("burst_span", cyc - first_cyc, 32'd7);
                                busy        = 1'b0;
                                seen_first  = 1'b0;
                                hs_in_burst = 0;
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic mem_write(input int unsigned a, input logic [31:0] d);
        init_wen   = 1'b1;
        init_addr  = 12'(a % DEPTH);
        init_wdata = d;
        model[a % DEPTH] = d;
        @(posedge clk);
        #1;
        init_wen = 1'b0;
    endtask

    // Leaves req_valid high; callers drop it when no follow-up request is wanted.
    task automatic send_req(input logic [31:0] addr);
        int unsigned waited = 0;
        bit          got = 1'b0;
        int unsigned base;
        req_valid = 1'b1;
        req_addr  = addr;
        while (!got && waited < 300) begin
            @(negedge clk);
            if (req_ready && !rst) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            fail_now("req_accept");
            req_valid = 1'b0;
            return;
        end
        first_q.push_back(cyc + 1 + LAT);
        base = ((addr >> 2) & 32'hFFFF_FFF8) % DEPTH;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back('{data: model[(base + k) % DEPTH], last: (k == 7)});
        end
        busy = 1'b1;
    endtask

    task automatic drain();
        int unsigned w = 0;
        while ((exp_q.size() != 0 || busy) && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (w >= 600) fail_now("burst_drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned hs_before;
        int unsigned w;
        int unsigned c0;
        bit          got;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_last", 32'(rsp_last), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);

        for (int unsigned a = 0; a < DEPTH; a++) mem_write(a, $urandom);
        for (int unsigned k = 0; k < 8; k++) mem_write(32'h40 + k, 32'hA0 + k);
        rst = 1'b0;
        @(posedge clk);
        #1;

        ready_mode = 0;
        send_req(32'h0000_0100);
        req_valid = 1'b0;
        drain();

        ready_mode = 1;
        hs_before = hs_total;
        send_req(32'h0000_0100);
        req_valid = 1'b0;
        drain();
        chk("handshake_count", hs_total - hs_before, 32'd8);

        ready_mode = 0;
        send_req(32'h0000_011C);
        req_valid = 1'b0;
        drain();
        send_req(32'h0004_0100);
        req_valid = 1'b0;
        drain();

        ready_mode = 2;
        send_req(32'h0000_0100);
        send_req($urandom);
        req_valid = 1'b0;
        drain();

        ready_mode = 0;
        send_req(32'h0000_0100);
        req_valid = 1'b0;
        w = 0;
        while (hs_in_burst < 3 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) fail_now("reach_beat3");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        first_q.delete();
        busy        = 1'b0;
        seen_first  = 1'b0;
        hs_in_burst = 0;
        @(posedge clk);
        #1;
        send_req(32'h0000_0100);
        req_valid = 1'b0;
        drain();

        for (int n = 0; n < 30; n++) begin
            ready_mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) mem_write($urandom, $urandom);
            send_req($urandom);
            if ($urandom_range(0, 3) == 0) send_req($urandom);
            req_valid = 1'b0;
            drain();
        end

        for (int unsigned k = 0; k < 8; k++) begin
            init_wen0   = 1'b1;
            init_addr0  = 12'(32'h40 + k);
            init_wdata0 = 32'hB0 + k;
            @(posedge clk);
            #1;
        end
        init_wen0  = 1'b0;
        req_valid0 = 1'b1;
        req_addr0  = 32'h0000_0100;
        got = 1'b0;
        c0  = 0;
        w   = 0;
        while (!got && w < 50) begin
            @(negedge clk);
            if (req_ready0) begin
                got = 1'b1;
                c0  = cyc;
            end else begin
                w++;
            end
        end
        if (!got) fail_now("lat0_accept");
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk("lat0_first_cycle", cyc, c0 + 1);
            chk("lat0_valid", 32'(rsp_valid0), 32'd1);
            chk("lat0_data", rsp_data0, 32'hB0 + k);
            chk("lat0_last", 32'(rsp_last0), 32'(k == 7));
        end
        @(negedge clk);
        chk("lat0_valid_after", 32'(rsp_valid0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
